// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multicycle accumulator machine: FSM states, opcodes,
// ALU operations, ALU source selects, memory address select and the control word.
package multicycle_control_pkg;

  typedef enum logic [3:0] {
    S_START     = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_MEM_READ  = 4'd3,
    S_ALU_EXEC  = 4'd4,
    S_WRITEBACK = 4'd5,
    S_STORE     = 4'd6,
    S_BRANCH    = 4'd7,
    S_JUMP      = 4'd8,
    S_SP_CALC   = 4'd9,
    S_HALT      = 4'd10
  } state_t;

  typedef enum logic [3:0] {
    OP_ADD  = 4'h0,
    OP_SUB  = 4'h1,
    OP_AND  = 4'h2,
    OP_OR   = 4'h3,
    OP_ADDI = 4'h4,
    OP_LD   = 4'h5,
    OP_ST   = 4'h6,
    OP_BEQ  = 4'h7,
    OP_BLE  = 4'h8,
    OP_J    = 4'h9,
    OP_PUSH = 4'hA,
    OP_HALT = 4'hF
  } op_t;

  typedef enum logic [2:0] {
    ALU_ADD   = 3'b000,
    ALU_SUB   = 3'b001,
    ALU_AND   = 3'b010,
    ALU_OR    = 3'b011,
    ALU_PASSB = 3'b100
  } alu_op_t;

  typedef enum logic [1:0] {
    ASA_ACC = 2'b00,
    ASA_PC  = 2'b01,
    ASA_SP  = 2'b10
  } asa_t;

  typedef enum logic [1:0] {
    ASB_MEM  = 2'b00,
    ASB_ONE  = 2'b01,
    ASB_IMM  = 2'b10,
    ASB_ZERO = 2'b11
  } asb_t;

  typedef enum logic [1:0] {
    MAS_PC     = 2'b00,
    MAS_IMM    = 2'b01,
    MAS_ALUOUT = 2'b10
  } mas_t;

  typedef struct packed {
    logic    pc_write;
    logic    pc_src;
    logic    ir_write;
    logic    mem_read;
    logic    mem_write;
    logic    acc_write;
    logic    aluout_write;
    logic    sp_write;
    mas_t    mem_addr_src;
    asa_t    asa_op;
    asb_t    asb_op;
    alu_op_t alu_op;
    logic    halted;
  } ctrl_t;

  function automatic logic is_legal(input logic [3:0] op);
    return (op <= 4'hA) || (op == 4'hF);
  endfunction

  function automatic alu_op_t exec_alu(input logic [3:0] op);
    case (op)
      OP_SUB:  return ALU_SUB;
      OP_AND:  return ALU_AND;
      OP_OR:   return ALU_OR;
      OP_LD:   return ALU_PASSB;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_control_decode.sv
// Combinational control-word decode from the current state and latched opcode;
// the only live inputs are the memory handshake and the branch compare flags.
module control_decode
  import multicycle_control_pkg::*;
(
  input  state_t     state,
  input  logic [3:0] op,
  input  logic       mem_ready,
  input  logic       branch_result,
  input  logic       ble_result,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_read     = 1'b1;
        ctrl.mem_addr_src = MAS_PC;
        ctrl.asa_op       = ASA_PC;
        ctrl.asb_op       = ASB_ONE;
        ctrl.alu_op       = ALU_ADD;
        ctrl.ir_write     = mem_ready;
        ctrl.pc_write     = mem_ready;
      end
      S_DECODE: begin
        // Branch/jump target PC+imm is parked in ALUOut for later states.
        ctrl.asa_op       = ASA_PC;
        ctrl.asb_op       = ASB_IMM;
        ctrl.alu_op       = ALU_ADD;
        ctrl.aluout_write = 1'b1;
      end
      S_MEM_READ: begin
        ctrl.mem_read     = 1'b1;
        ctrl.mem_addr_src = MAS_IMM;
      end
      S_ALU_EXEC: begin
        ctrl.asa_op       = ASA_ACC;
        ctrl.asb_op       = (op == OP_ADDI) ? ASB_IMM : ASB_MEM;
        ctrl.alu_op       = exec_alu(op);
        ctrl.aluout_write = 1'b1;
      end
      S_WRITEBACK: ctrl.acc_write = 1'b1;
      S_STORE: begin
        ctrl.mem_write    = 1'b1;
        ctrl.mem_addr_src = (op == OP_PUSH) ? MAS_ALUOUT : MAS_IMM;
        ctrl.asa_op       = ASA_ACC;
        ctrl.asb_op       = ASB_ZERO;
        ctrl.alu_op       = ALU_ADD;
        ctrl.sp_write     = (op == OP_PUSH) && mem_ready;
      end
      S_BRANCH: begin
        ctrl.asa_op   = ASA_ACC;
        ctrl.asb_op   = ASB_ZERO;
        ctrl.alu_op   = ALU_SUB;
        ctrl.pc_src   = 1'b1;
        ctrl.pc_write = (op == OP_BLE) ? ble_result : branch_result;
      end
      S_JUMP: begin
        ctrl.pc_write = 1'b1;
        ctrl.pc_src   = 1'b1;
      end
      S_SP_CALC: begin
        ctrl.asa_op       = ASA_SP;
        ctrl.asb_op       = ASB_ONE;
        ctrl.alu_op       = ALU_SUB;
        ctrl.aluout_write = 1'b1;
      end
      S_HALT:  ctrl.halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle accumulator-machine controller: state register, opcode latch,
// sticky illegal-opcode flag and next-state logic around control_decode.
module multicycle_control
  import multicycle_control_pkg::*;
(
  input  logic       CLK,
  input  logic       reset,
  input  logic [3:0] opcode,
  input  logic       mem_ready,
  input  logic       BranchResult,
  input  logic       BLEResult,
  output logic       PCWrite,
  output logic       PCSrc,
  output logic       IRWrite,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       AccWrite,
  output logic       ALUOutWrite,
  output logic       SpWrite,
  output logic [1:0] MemAddrSrc,
  output logic [1:0] ASA_op,
  output logic [1:0] ASB_op,
  output logic [2:0] ALU_op,
  output logic       halted,
  output logic       illegal_op,
  output logic [3:0] state
);

  state_t     state_q, state_nxt;
  logic [3:0] op_q;
  logic       illegal_q;
  ctrl_t      ctrl;

  // START decodes to an all-zero control word, so the async reset of the
  // state register alone clears every output immediately.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) state_q <= S_START;
    else        state_q <= state_nxt;
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset)                                         illegal_q <= 1'b0;
    else if (state_q == S_DECODE && !is_legal(opcode))  illegal_q <= 1'b1;
  end

  // Opcode is only consumed after DECODE, so it needs no reset.
  always_ff @(posedge CLK) begin
    if (state_q == S_DECODE) op_q <= opcode;
  end

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      S_START:  state_nxt = S_FETCH;
      S_FETCH:  if (mem_ready) state_nxt = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_LD: state_nxt = S_MEM_READ;
          OP_ADDI:                              state_nxt = S_ALU_EXEC;
          OP_ST:                                state_nxt = S_STORE;
          OP_BEQ, OP_BLE:                       state_nxt = S_BRANCH;
          OP_J:                                 state_nxt = S_JUMP;
          OP_PUSH:                              state_nxt = S_SP_CALC;
          default:                              state_nxt = S_HALT;
        endcase
      end
      S_MEM_READ:  if (mem_ready) state_nxt = S_ALU_EXEC;
      S_ALU_EXEC:  state_nxt = S_WRITEBACK;
      S_WRITEBACK: state_nxt = S_FETCH;
      S_STORE:     if (mem_ready) state_nxt = S_FETCH;
      S_BRANCH:    state_nxt = S_FETCH;
      S_JUMP:      state_nxt = S_FETCH;
      S_SP_CALC:   state_nxt = S_STORE;
      S_HALT:      state_nxt = S_HALT;
      default:     state_nxt = S_START;
    endcase
  end

  control_decode u_decode (
    .state         (state_q),
    .op            (op_q),
    .mem_ready     (mem_ready),
    .branch_result (BranchResult),
    .ble_result    (BLEResult),
    .ctrl          (ctrl)
  );

  assign PCWrite     = ctrl.pc_write;
  assign PCSrc       = ctrl.pc_src;
  assign IRWrite     = ctrl.ir_write;
  assign MemRead     = ctrl.mem_read;
  assign MemWrite    = ctrl.mem_write;
  assign AccWrite    = ctrl.acc_write;
  assign ALUOutWrite = ctrl.aluout_write;
  assign SpWrite     = ctrl.sp_write;
  assign MemAddrSrc  = ctrl.mem_addr_src;
  assign ASA_op      = ctrl.asa_op;
  assign ASB_op      = ctrl.asb_op;
  assign ALU_op      = ctrl.alu_op;
  assign halted      = ctrl.halted;
  assign illegal_op  = illegal_q;
  assign state       = state_q;

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have port CLK, input, 1 bit: single rising-edge clock.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port opcode, input, 4 bits: IR[15:12], stable from DECODE until the next FETCH.
REQ-004 SHALL have port mem_ready, input, 1 bit: memory completes the current read/write this cycle.
REQ-005 SHALL have ports BranchResult and BLEResult, input, 1 bit each: ALU compare flags (equal; less-or-equal).
REQ-006 SHALL have outputs PCWrite, PCSrc, IRWrite, MemRead, MemWrite, AccWrite, ALUOutWrite, SpWrite, 1 bit each: datapath strobes; PCSrc 0 = ALU result, 1 = ALUOut.
REQ-007 SHALL have output MemAddrSrc, 2 bits: 00 PC, 01 imm, 10 ALUOut.
REQ-008 SHALL have outputs ASA_op and ASB_op, 2 bits each: ASA 00 ACC, 01 PC, 10 SP; ASB 00 MemData, 01 const 1, 10 sign-extended imm, 11 zero.
REQ-009 SHALL have output ALU_op, 3 bits: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 PASSB.
REQ-010 SHALL have outputs halted and illegal_op, 1 bit each, and state, 4 bits: current state, for debug.

Function
REQ-011 SHALL be a Moore FSM with states START, FETCH, DECODE, MEM_READ, ALU_EXEC, WRITEBACK, STORE, BRANCH, JUMP, SP_CALC, HALT; outputs decode from state and the latched opcode only.
REQ-012 SHALL drive every strobe to 0 and every select to 00 in any state that does not list it.
REQ-013 SHALL use opcodes 0 ADD, 1 SUB, 2 AND, 3 OR (ACC op M[imm]); 4 ADDI; 5 LD; 6 ST; 7 BEQ (ACC==0); 8 BLE (ACC<=0); 9 J; A PUSH; F HALT; all others illegal.
REQ-014 SHALL move START -> FETCH unconditionally on the first edge; START asserts nothing.
REQ-015 In FETCH SHALL assert MemRead, MemAddrSrc=00, ASA=PC, ASB=1, ADD; SHALL assert IRWrite and PCWrite (PCSrc=0) only in the cycle mem_ready=1, then go to DECODE; otherwise hold in FETCH.
REQ-016 In DECODE SHALL compute PC+imm (ASA=PC, ASB=imm, ADD, ALUOutWrite) and then go: ops 0-3,5 -> MEM_READ; 4 -> ALU_EXEC; 6 -> STORE; 7,8 -> BRANCH; 9 -> JUMP; A -> SP_CALC; F -> HALT; illegal -> HALT with illegal_op set.
REQ-017 In MEM_READ SHALL assert MemRead with MemAddrSrc=01, hold until mem_ready=1, then go to ALU_EXEC.
REQ-018 In ALU_EXEC SHALL assert ALUOutWrite with ASA=ACC; ASB=MemData for ops 0-3 and 5, imm for op 4; ALU_op = ADD/SUB/AND/OR/ADD/PASSB for ops 0/1/2/3/4/5; then go to WRITEBACK.
REQ-019 In WRITEBACK SHALL assert AccWrite for exactly one cycle, then go to FETCH.
REQ-020 In STORE SHALL assert MemWrite with ASA=ACC, ASB=zero, ADD; MemAddrSrc=01 for ST and 10 for PUSH; SHALL hold until mem_ready=1; for PUSH SHALL assert SpWrite in the mem_ready cycle only; then go to FETCH.
REQ-021 In BRANCH SHALL apply ASA=ACC, ASB=zero, SUB, PCSrc=1; PCWrite = BranchResult for BEQ and BLEResult for BLE; then go to FETCH.
REQ-022 In JUMP SHALL assert PCWrite with PCSrc=1, then go to FETCH.
REQ-023 In SP_CALC SHALL compute SP-1 (ASA=SP, ASB=1, SUB, ALUOutWrite), then go to STORE.
REQ-024 HALT SHALL be absorbing until reset, with halted=1 and all strobes 0; illegal_op SHALL be sticky until reset.
REQ-025 Cycle counts with mem_ready always 1: ALU ops and LD 5 cycles; ADDI and PUSH 4; ST, BEQ, BLE and J 3.

Reset
REQ-026 When reset=0, SHALL force state=START, all outputs 0, and clear halted and illegal_op immediately, independent of CLK, including mid-instruction and mid-memory-wait.
REQ-027 After reset deasserts, SHALL take exactly one edge to reach FETCH.

Structure
REQ-028 The opcode, state, ALU_op, ASA/ASB select and MemAddrSrc encodings SHALL live in a shared package, also used by the ALU source muxes and the ALU.
REQ-029 SHALL use one sub-module, control_decode: combinational state/opcode -> outputs; the next-state register stays in the top module.

Verification
REQ-030 Reset mid-MEM_READ: reset=0 during MEM_READ -> outputs 0 and state=START at once; FETCH one edge after release.
REQ-031 ADDI with mem_ready=1 -> states FETCH, DECODE, ALU_EXEC, WRITEBACK, FETCH; ALU_op=000, ASB_op=10, AccWrite high exactly one cycle.
REQ-032 LD with mem_ready low for 3 cycles in MEM_READ -> MEM_READ held 4 cycles, AccWrite not asserted until WRITEBACK, ALU_op=100 in ALU_EXEC.
REQ-033 BEQ with BranchResult=1, then BEQ with BranchResult=0 -> PCWrite=1 with PCSrc=1 in BRANCH, then PCWrite=0 in BRANCH.
REQ-034 PUSH -> SP_CALC shows ASA_op=10, ALU_op=001; STORE shows MemAddrSrc=10 and SpWrite=1 only in the mem_ready cycle.
REQ-035 Opcode 4'hC -> HALT with illegal_op=1 and halted=1, held for 10 cycles; reset clears both flags.
